// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - read-side FIFO controller feeding a valid/ready stream through a 2-entry buffer
//
// Pops words from a FIFO whose data_out is registered one cycle after an
// accepted pop, and presents them in order on the m_* stream. A 2-entry output
// buffer lets the reader sustain one word per cycle while m_ready stays high.
//
// Parameters:
//  DATA_WIDTH     width of the FIFO word and of m_data
//  CNT_WIDTH      width of the saturating words-delivered counter
//
// Ports:
//  clk            clock, rising edge
//  rst_n          reset, asynchronous, active-low
//  enable         1 = allowed to run and issue pops; 0 = stop issuing pops
//  flush          1-cycle pulse: discard buffered and in-flight data
//  fifo_empty     FIFO empty flag
//  fifo_push      producer's push into the FIFO (push wins over pop there)
//  fifo_data_out  FIFO registered read data
//  fifo_pop_err   FIFO pop-on-empty error indication
//  fifo_pop       pop request to the FIFO (combinational)
//  m_valid        output word valid
//  m_ready        downstream ready; transfer when m_valid & m_ready
//  m_data         output word (buffer head)
//  word_cnt       number of words delivered, saturating
//  proto_err      sticky FIFO pop error flag, cleared by flush or reset

module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic                  fifo_push,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_pop_err,
    output logic                  fifo_pop,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic                  proto_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Output buffer: two slots addressed by 1-bit read/write pointers.
    logic [DATA_WIDTH-1:0] slot0;
    logic [DATA_WIDTH-1:0] slot1;
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            occ;
    logic [1:0]            occ_nxt;

    // pend marks a pop issued on the previous edge whose word is now on
    // fifo_data_out and must be written into the buffer tail.
    logic                  pend;

    logic                  deq;
    logic                  capture;
    logic [2:0]            fill;
    logic                  pop_ok;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    assign deq     = m_valid & m_ready;
    // A word landing during a flush belongs to discarded traffic.
    assign capture = pend & ~flush;

    // Entries committed after this edge if no new pop is issued: buffered
    // words plus the in-flight one, minus the one leaving this cycle.
    // deq implies occ >= 1, so this never underflows.
    assign fill = {1'b0, occ} + {2'b00, pend} - {2'b00, deq};

    // fifo_push blocks the pop because the FIFO would silently ignore it,
    // which would leave pend set for a word that never arrives. flush blocks
    // it so no new word is in flight after the buffer has been cleared.
    assign pop_ok = (state == S_RUN) && !flush && !fifo_empty && !fifo_push &&
                    (fill < 3'd2);

    assign fifo_pop = pop_ok;

    assign m_valid = (occ != 2'd0);
    assign m_data  = rd_ptr ? slot1 : slot0;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (enable) state_nxt = S_RUN;
            S_RUN:   if (!enable) state_nxt = S_IDLE;
            S_FLUSH: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush) begin
            state_nxt = S_FLUSH;
        end
    end

    // ------------------------------------------------------------------
    // Buffer occupancy: a capture and a dequeue on one edge cancel out.
    // ------------------------------------------------------------------
    always_comb begin
        occ_nxt = occ;
        if (capture && !deq) begin
            occ_nxt = occ + 2'd1;
        end else if (!capture && deq) begin
            occ_nxt = occ - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ    <= 2'd0;
            pend   <= 1'b0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            slot0  <= '0;
            slot1  <= '0;
        end else if (flush) begin
            occ    <= 2'd0;
            pend   <= 1'b0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            occ  <= occ_nxt;
            pend <= fifo_pop;
            if (capture) begin
                if (wr_ptr) begin
                    slot1 <= fifo_data_out;
                end else begin
                    slot0 <= fifo_data_out;
                end
                wr_ptr <= ~wr_ptr;
            end
            if (deq) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Delivered-word counter and sticky error flag. A transfer on the
    // flush cycle still completes, so it is counted regardless of flush.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt  <= '0;
            proto_err <= 1'b0;
        end else begin
            if (deq && (word_cnt != CNT_MAX)) begin
                word_cnt <= word_cnt + 1'b1;
            end
            if (flush) begin
                proto_err <= 1'b0;
            end else if (fifo_pop_err) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - self-checking bench for fifo_stream_reader

module tb_fifo_stream_reader;

    localparam int DW      = 8;
    localparam int CW      = 4;
    localparam int CNT_MAX = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          flush;
    logic          fifo_empty = 1'b1;
    logic          fifo_push;
    logic [DW-1:0] fifo_data_out = '0;
    logic          fifo_pop_err;
    logic          fifo_pop;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [CW-1:0] word_cnt;
    logic          proto_err;
    logic [DW-1:0] push_data;

    int checks      = 0;
    int errors      = 0;
    int cyc         = 0;
    int pops        = 0;
    int exp_cnt     = 0;
    int first_pop   = -1;
    int first_valid = -1;

    logic [DW-1:0] fq[$];      // contents of the FIFO in front of the reader
    logic [DW-1:0] exp_q[$];   // words popped and not yet delivered or discarded
    logic [DW-1:0] got[$];     // every word delivered on m_*
    int            deq_cyc[$];
    logic          stall = 1'b0;
    logic [DW-1:0] stall_data = '0;
    logic [DW-1:0] model_w;

    fifo_stream_reader #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .flush         (flush),
        .fifo_empty    (fifo_empty),
        .fifo_push     (fifo_push),
        .fifo_data_out (fifo_data_out),
        .fifo_pop_err  (fifo_pop_err),
        .fifo_pop      (fifo_pop),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .word_cnt      (word_cnt),
        .proto_err     (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // FIFO behaviour: push wins over pop, data_out registered on an accepted pop.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (fifo_push) begin
            fq.push_back(push_data);
        end else if (fifo_pop && fq.size() != 0) begin
            model_w = fq.pop_front();
            fifo_data_out <= model_w;
            exp_q.push_back(model_w);
        end
        fifo_empty <= (fq.size() == 0);
    end

    // Stream monitor and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_cnt = 0;
            stall   = 1'b0;
        end else begin
            check("word_cnt", word_cnt, exp_cnt);
            if (stall) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, stall_data);
            end
            if (fifo_push) check("push_blocks_pop", fifo_pop, 0);
            if (fifo_pop) begin
                check("pop_on_empty", fifo_empty, 0);
                pops++;
                if (first_pop < 0) first_pop = cyc;
            end
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (m_valid && m_ready) begin
                check("deq_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    check("deq_data", m_data, exp_q[0]);
                    void'(exp_q.pop_front());
                end
                got.push_back(m_data);
                deq_cyc.push_back(cyc);
                if (exp_cnt < CNT_MAX) exp_cnt++;
            end
            if (flush) exp_q.delete();
            stall      = m_valid && !m_ready && !flush;
            stall_data = m_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo_push = 1'b1;
        push_data = w;
        tick();
        fifo_push = 1'b0;
    endtask

    task automatic wait_deliv(input int n, input string tag);
        int k = 0;
        while (got.size() < n && k < 400) begin
            tick();
            k++;
        end
        check(tag, (got.size() >= n), 1);
    endtask

    task automatic wait_pops(input int n, input string tag);
        int k = 0;
        @(negedge clk);
        while (pops < n && k < 50) begin
            @(negedge clk);
            k++;
        end
        check(tag, (pops >= n), 1);
    endtask

    initial begin
        logic [DW-1:0] words[8];
        int            base;
        int            pbase;
        int            k;

        rst_n        = 1'b0;
        enable       = 1'b0;
        flush        = 1'b0;
        fifo_push    = 1'b0;
        fifo_pop_err = 1'b0;
        m_ready      = 1'b0;
        push_data    = '0;

        // Reset values
        tick();
        enable = 1'b1;
        @(negedge clk);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_word_cnt", word_cnt, 0);
        check("rst_proto_err", proto_err, 0);
        check("rst_fifo_pop", fifo_pop, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: three words, buffer fills to two, then stream back-to-back
        push(8'hA1);
        push(8'hB2);
        push(8'hC3);
        repeat (6) tick();
        check("t1_pops_stalled", pops, 2);
        m_ready = 1'b1;
        wait_deliv(3, "t1_deliver_timeout");
        m_ready = 1'b0;
        check("t1_word0", got[0], 8'hA1);
        check("t1_word1", got[1], 8'hB2);
        check("t1_word2", got[2], 8'hC3);
        check("t1_consec01", deq_cyc[1] - deq_cyc[0], 1);
        check("t1_consec12", deq_cyc[2] - deq_cyc[1], 1);
        check("t1_latency", first_valid - first_pop, 2);
        @(negedge clk);
        check("t1_word_cnt", word_cnt, 3);
        tick();

        // 2: five words with a stalled consumer -> exactly two pops
        base  = got.size();
        pbase = pops;
        for (int i = 0; i < 5; i++) begin
            words[i] = DW'($urandom_range(0, 255));
            push(words[i]);
        end
        repeat (6) tick();
        check("t2_two_pops", pops - pbase, 2);
        @(negedge clk);
        check("t2_pop_idle", fifo_pop, 0);
        check("t2_valid", m_valid, 1);
        tick();
        m_ready = 1'b1;
        wait_deliv(base + 5, "t2_deliver_timeout");
        for (int i = 0; i < 5; i++) check("t2_order", got[base + i], words[i]);
        repeat (3) tick();
        check("t2_no_extra", got.size(), base + 5);

        // 3: push on every other cycle while the reader drains randomly
        base = got.size();
        for (int i = 0; i < 8; i++) begin
            words[i] = DW'($urandom_range(0, 255));
            m_ready  = 1'($urandom_range(0, 1));
            push(words[i]);
            m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        m_ready = 1'b1;
        wait_deliv(base + 8, "t3_deliver_timeout");
        for (int i = 0; i < 8; i++) check("t3_order", got[base + i], words[i]);
        m_ready = 1'b0;
        tick();

        // 4a: flush with a word buffered and one in flight
        base  = got.size();
        pbase = pops;
        for (int i = 0; i < 5; i++) begin
            words[i] = DW'($urandom_range(0, 255));
            push(words[i]);
        end
        wait_pops(pbase + 2, "t4_two_pops");
        @(posedge clk);
        #1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("t4_valid_after_flush", m_valid, 0);
        check("t4_pop_in_flush", fifo_pop, 0);
        tick();
        m_ready = 1'b1;
        wait_deliv(base + 3, "t4_deliver_timeout");
        check("t4_next_unread", got[base], words[2]);
        check("t4_next_unread1", got[base + 1], words[3]);
        check("t4_next_unread2", got[base + 2], words[4]);
        m_ready = 1'b0;
        repeat (2) tick();

        // 4b: flush on the same cycle as a transfer -> transfer counted
        base = got.size();
        push(8'h5A);
        push(8'h6B);
        repeat (6) tick();
        m_ready = 1'b1;
        flush   = 1'b1;
        tick();
        flush   = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        check("t4b_delivered", got.size(), base + 1);
        check("t4b_word", got[base], 8'h5A);
        check("t4b_valid", m_valid, 0);
        repeat (3) tick();

        // 4c: enable dropped with a pop in flight -> word still delivered
        base  = got.size();
        pbase = pops;
        push(8'h77);
        wait_pops(pbase + 1, "t4c_pop");
        @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (2) tick();
        push(8'h88);
        repeat (4) tick();
        check("t4c_no_pop_disabled", pops - pbase, 1);
        @(negedge clk);
        check("t4c_captured", m_valid, 1);
        tick();
        m_ready = 1'b1;
        wait_deliv(base + 1, "t4c_deliver_timeout");
        check("t4c_word", got[base], 8'h77);
        enable = 1'b1;
        wait_deliv(base + 2, "t4c_resume_timeout");
        check("t4c_word2", got[base + 1], 8'h88);
        m_ready = 1'b0;
        tick();

        // 5: sticky protocol error, cleared by flush
        fifo_pop_err = 1'b1;
        tick();
        fifo_pop_err = 1'b0;
        @(negedge clk);
        check("t5_err_set", proto_err, 1);
        repeat (3) tick();
        @(negedge clk);
        check("t5_err_sticky", proto_err, 1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("t5_err_cleared", proto_err, 0);
        repeat (2) tick();

        // 6: counter saturation after a fresh reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        base = got.size();
        for (int i = 0; i < 20; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            push(DW'($urandom_range(0, 255)));
        end
        k = 0;
        while (got.size() < base + 20 && k < 400) begin
            m_ready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        check("t6_deliver20", got.size(), base + 20);
        m_ready = 1'b0;
        @(negedge clk);
        check("t6_saturated", word_cnt, 15);
        tick();

        // 6b: asynchronous reset mid-stream
        for (int i = 0; i < 4; i++) push(DW'($urandom_range(0, 255)));
        repeat (4) tick();
        @(negedge clk);
        check("t6_valid_before_rst", m_valid, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", m_valid, 0);
        check("t6_rst_cnt", word_cnt, 0);
        check("t6_rst_pop", fifo_pop, 0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        base    = got.size();
        m_ready = 1'b1;
        k       = 0;
        while ((fq.size() != 0 || m_valid || got.size() < base + 2) && k < 100) begin
            tick();
            k++;
        end
        check("t6_remaining", got.size(), base + 2);
        @(negedge clk);
        check("t6_post_cnt", word_cnt, 2);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
